hv_reg_acc_rr_arb: RTL and testbench

Parametrised register-access arbiter that merges CH_NUM independent requesters (SPI slave, OWT/D2D DPU, test port, ...) onto the single reg_access_ctrl (RAC) port of the HV die. Grants are round-robin and transaction-locked: one request is latched and held on the RAC port until acknowledged. The acknowledge and read data are routed back only to the granted channel. An optional watchdog aborts a hung access.

---
 rtl/hv_reg_acc_rr_arb_pkg.sv | 20 ++
 rtl/hv_reg_acc_rr_arb_if.sv | 53 +++++
 rtl/hv_reg_acc_rr_arb_rr_pick.sv | 30 +++
 rtl/hv_reg_acc_rr_arb.sv | 136 +++++++++++++
 tb/tb_hv_reg_acc_rr_arb.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_reg_acc_rr_arb_pkg.sv
// Shared types for the HV register-access arbiter: FSM state, request type
// and the channel-index width helper.
package hv_acc_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } req_e;

  // CH_IDX_W as a function of CH_NUM; never narrower than one bit.
  function automatic int ch_idx_w(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/hv_reg_acc_rr_arb_if.sv
// Channel-side and RAC-side signals of the register-access arbiter.
// master = arbiter view, slave = requesters/RAC view.
interface hv_reg_acc_rr_arb_if #(
  parameter int CH_NUM    = 2,
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8
);
  import hv_acc_arb_pkg::*;

  localparam int CH_IDX_W = ch_idx_w(CH_NUM);

  logic [CH_NUM-1:0]                 i_ch_wr_req;
  logic [CH_NUM-1:0]                 i_ch_rd_req;
  logic [CH_NUM-1:0][REG_AW-1:0]     i_ch_addr;
  logic [CH_NUM-1:0][REG_DW-1:0]     i_ch_wdata;
  logic [CH_NUM-1:0][REG_CRC_W-1:0]  i_ch_wcrc;
  logic [CH_NUM-1:0]                 o_ch_wack;
  logic [CH_NUM-1:0]                 o_ch_rack;
  logic [REG_DW-1:0]                 o_ch_rdata;
  logic [REG_AW-1:0]                 o_ch_raddr;
  logic [CH_NUM-1:0]                 o_ch_tout;

  logic                              o_rac_wr_req;
  logic                              o_rac_rd_req;
  logic [REG_AW-1:0]                 o_rac_addr;
  logic [REG_DW-1:0]                 o_rac_wdata;
  logic [REG_CRC_W-1:0]              o_rac_wcrc;
  logic                              i_rac_wack;
  logic                              i_rac_rack;
  logic [REG_DW-1:0]                 i_rac_data;
  logic [REG_AW-1:0]                 i_rac_addr;

  logic                              o_busy;
  logic [CH_IDX_W-1:0]               o_gnt_id;

  modport master (
    input  i_ch_wr_req, i_ch_rd_req, i_ch_addr, i_ch_wdata, i_ch_wcrc,
    input  i_rac_wack, i_rac_rack, i_rac_data, i_rac_addr,
    output o_ch_wack, o_ch_rack, o_ch_rdata, o_ch_raddr, o_ch_tout,
    output o_rac_wr_req, o_rac_rd_req, o_rac_addr, o_rac_wdata, o_rac_wcrc,
    output o_busy, o_gnt_id
  );

  modport slave (
    output i_ch_wr_req, i_ch_rd_req, i_ch_addr, i_ch_wdata, i_ch_wcrc,
    output i_rac_wack, i_rac_rack, i_rac_data, i_rac_addr,
    input  o_ch_wack, o_ch_rack, o_ch_rdata, o_ch_raddr, o_ch_tout,
    input  o_rac_wr_req, o_rac_rd_req, o_rac_addr, o_rac_wdata, o_rac_wcrc,
    input  o_busy, o_gnt_id
  );

endinterface

// File: rtl/hv_reg_acc_rr_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after
// ptr, wrapping modulo CH_NUM.
module hv_rr_pick
  import hv_acc_arb_pkg::*;
#(
  parameter int CH_NUM   = 2,
  parameter int CH_IDX_W = ch_idx_w(CH_NUM)
) (
  input  logic [CH_NUM-1:0]   req,
  input  logic [CH_IDX_W-1:0] ptr,
  output logic [CH_IDX_W-1:0] win,
  output logic                vld
);

  int idx;

  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = 0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = (int'(ptr) + i) % CH_NUM;
      if (!vld && req[idx]) begin
        vld = 1'b1;
        win = CH_IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hv_reg_acc_rr_arb.sv
// Round-robin, transaction-locked arbiter merging CH_NUM requesters onto the
// single RAC port. Optional watchdog enabled by `define HV_ACC_ARB_TOUT_EN.
module hv_reg_acc_rr_arb
  import hv_acc_arb_pkg::*;
#(
  parameter int CH_NUM    = 2,
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int TOUT_CYC  = 255
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  hv_reg_acc_rr_arb_if.master bus
);

  localparam int CH_IDX_W = ch_idx_w(CH_NUM);

  state_e                state;
  req_e                  req_type;
  logic [CH_IDX_W-1:0]   rr_ptr;
  logic [CH_IDX_W-1:0]   gnt_id;
  logic                  rac_wr_req;
  logic                  rac_rd_req;
  logic [REG_AW-1:0]     rac_addr;
  logic [REG_DW-1:0]     rac_wdata;
  logic [REG_CRC_W-1:0]  rac_wcrc;

  logic [CH_NUM-1:0]     req_vec;
  logic [CH_IDX_W-1:0]   win;
  logic                  win_vld;
  logic                  wack_hit;
  logic                  rack_hit;
  logic                  ack_done;
  logic                  tout_hit;
  logic [CH_NUM-1:0]     gnt_onehot;

  assign req_vec = bus.i_ch_wr_req | bus.i_ch_rd_req;

  hv_rr_pick #(
    .CH_NUM   (CH_NUM),
    .CH_IDX_W (CH_IDX_W)
  ) u_pick (
    .req (req_vec),
    .ptr (rr_ptr),
    .win (win),
    .vld (win_vld)
  );

  // Only an ack matching the latched request type completes a transaction.
  assign wack_hit = (state == BUSY) && (req_type == REQ_WR) && bus.i_rac_wack;
  assign rack_hit = (state == BUSY) && (req_type == REQ_RD) && bus.i_rac_rack;
  assign ack_done = wack_hit || rack_hit;

`ifdef HV_ACC_ARB_TOUT_EN
  localparam int TCNT_W = $clog2(TOUT_CYC + 1);

  logic [TCNT_W-1:0] tout_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tout_cnt <= '0;
    end else if (state == IDLE) begin
      tout_cnt <= '0;
    end else begin
      tout_cnt <= tout_cnt + TCNT_W'(1);
    end
  end

  // Counter is 0 in the first BUSY cycle, so the limit lands on BUSY cycle TOUT_CYC.
  assign tout_hit = (state == BUSY) && !ack_done &&
                    (tout_cnt == TCNT_W'(TOUT_CYC - 1));
`else
  localparam int UNUSED_TOUT_CYC = TOUT_CYC;

  assign tout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      req_type   <= REQ_WR;
      rr_ptr     <= CH_IDX_W'(CH_NUM - 1);
      gnt_id     <= '0;
      rac_wr_req <= 1'b0;
      rac_rd_req <= 1'b0;
      rac_addr   <= '0;
      rac_wdata  <= '0;
      rac_wcrc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= BUSY;
            gnt_id    <= win;
            rr_ptr    <= win;
            rac_addr  <= bus.i_ch_addr[win];
            rac_wdata <= bus.i_ch_wdata[win];
            rac_wcrc  <= bus.i_ch_wcrc[win];
            if (bus.i_ch_wr_req[win]) begin
              req_type   <= REQ_WR;
              rac_wr_req <= 1'b1;
            end else begin
              req_type   <= REQ_RD;
              rac_rd_req <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (ack_done || tout_hit) begin
            state      <= IDLE;
            rac_wr_req <= 1'b0;
            rac_rd_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_onehot = CH_NUM'(1) << gnt_id;

  assign bus.o_ch_wack    = wack_hit ? gnt_onehot : '0;
  assign bus.o_ch_rack    = rack_hit ? gnt_onehot : '0;
  assign bus.o_ch_tout    = tout_hit ? gnt_onehot : '0;
  assign bus.o_ch_rdata   = rack_hit ? bus.i_rac_data : '0;
  assign bus.o_ch_raddr   = rack_hit ? bus.i_rac_addr : '0;
  assign bus.o_rac_wr_req = rac_wr_req;
  assign bus.o_rac_rd_req = rac_rd_req;
  assign bus.o_rac_addr   = rac_addr;
  assign bus.o_rac_wdata  = rac_wdata;
  assign bus.o_rac_wcrc   = rac_wcrc;
  assign bus.o_busy       = (state == BUSY);
  assign bus.o_gnt_id     = gnt_id;

endmodule

// File: tb/tb_hv_reg_acc_rr_arb.sv
// Directed bench for hv_reg_acc_rr_arb with three channels and TOUT_CYC=4;
// the watchdog steps are selected by HV_ACC_ARB_TOUT_EN.
module tb_hv_reg_acc_rr_arb;

  localparam int CH   = 3;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TOUT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_ch;

  hv_reg_acc_rr_arb_if #(
    .CH_NUM    (CH),
    .REG_AW    (AW),
    .REG_DW    (DW),
    .REG_CRC_W (CW)
  ) bus ();

  hv_reg_acc_rr_arb #(
    .CH_NUM    (CH),
    .REG_AW    (AW),
    .REG_DW    (DW),
    .REG_CRC_W (CW),
    .TOUT_CYC  (TOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are read on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit hit");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.i_ch_wr_req = '0;
    bus.i_ch_rd_req = '0;
    bus.i_ch_addr   = '0;
    bus.i_ch_wdata  = '0;
    bus.i_ch_wcrc   = '0;
    bus.i_rac_wack  = 1'b0;
    bus.i_rac_rack  = 1'b0;
    bus.i_rac_data  = '0;
    bus.i_rac_addr  = '0;

    #12;
    check_output("rst_busy",   bus.o_busy, 0);
    check_output("rst_wr_req", bus.o_rac_wr_req, 0);
    check_output("rst_rd_req", bus.o_rac_rd_req, 0);
    check_output("rst_gnt_id", bus.o_gnt_id, 0);
    check_output("rst_addr",   bus.o_rac_addr, 0);
    check_output("rst_wack",   bus.o_ch_wack, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single write from ch1.
    bus.i_ch_wr_req[1] = 1'b1;
    bus.i_ch_addr[1]   = 7'h12;
    bus.i_ch_wdata[1]  = 8'hA5;
    bus.i_ch_wcrc[1]   = 8'h5A;
    sample();
    check_output("wr_c0_req", bus.o_rac_wr_req, 0);
    next_cycle();
    sample();
    check_output("wr_c1_req",   bus.o_rac_wr_req, 1);
    check_output("wr_c1_addr",  bus.o_rac_addr, 32'h12);
    check_output("wr_c1_wdata", bus.o_rac_wdata, 32'hA5);
    check_output("wr_c1_wcrc",  bus.o_rac_wcrc, 32'h5A);
    check_output("wr_c1_gnt",   bus.o_gnt_id, 1);
    check_output("wr_c1_busy",  bus.o_busy, 1);
    next_cycle();
    sample();
    check_output("wr_c2_wack", bus.o_ch_wack, 0);
    check_output("wr_c2_req",  bus.o_rac_wr_req, 1);
    next_cycle();
    bus.i_rac_wack = 1'b1;
    sample();
    check_output("wr_c3_wack", bus.o_ch_wack, 3'b010);
    next_cycle();
    bus.i_rac_wack     = 1'b0;
    bus.i_ch_wr_req[1] = 1'b0;
    sample();
    check_output("wr_c4_req",  bus.o_rac_wr_req, 0);
    check_output("wr_c4_busy", bus.o_busy, 0);
    check_output("wr_c4_wack", bus.o_ch_wack, 0);

    // Read from ch0 with a wrong-type wack first.
    next_cycle();
    bus.i_ch_rd_req[0] = 1'b1;
    bus.i_ch_addr[0]   = 7'h05;
    next_cycle();
    bus.i_rac_wack = 1'b1;
    bus.i_rac_data = 8'h77;
    bus.i_rac_addr = 7'h05;
    sample();
    check_output("rd_req",        bus.o_rac_rd_req, 1);
    check_output("rd_gnt",        bus.o_gnt_id, 0);
    check_output("rd_stray_wack", bus.o_ch_wack, 0);
    check_output("rd_stray_rack", bus.o_ch_rack, 0);
    check_output("rd_idle_rdata", bus.o_ch_rdata, 0);
    next_cycle();
    bus.i_rac_wack = 1'b0;
    sample();
    check_output("rd_still_busy", bus.o_busy, 1);
    check_output("rd_still_req",  bus.o_rac_rd_req, 1);
    next_cycle();
    bus.i_rac_rack = 1'b1;
    bus.i_rac_data = 8'h3C;
    bus.i_rac_addr = 7'h05;
    sample();
    check_output("rd_rack",  bus.o_ch_rack, 3'b001);
    check_output("rd_rdata", bus.o_ch_rdata, 32'h3C);
    check_output("rd_raddr", bus.o_ch_raddr, 32'h05);
    next_cycle();
    bus.i_rac_rack     = 1'b0;
    bus.i_ch_rd_req[0] = 1'b0;
    sample();
    check_output("rd_done_req",   bus.o_rac_rd_req, 0);
    check_output("rd_done_rdata", bus.o_ch_rdata, 0);
    check_output("rd_done_rack",  bus.o_ch_rack, 0);

    // Acks while IDLE are dropped.
    next_cycle();
    bus.i_rac_wack = 1'b1;
    bus.i_rac_rack = 1'b1;
    bus.i_rac_data = 8'h99;
    sample();
    check_output("idle_wack",  bus.o_ch_wack, 0);
    check_output("idle_rack",  bus.o_ch_rack, 0);
    check_output("idle_rdata", bus.o_ch_rdata, 0);
    next_cycle();
    bus.i_rac_wack = 1'b0;
    bus.i_rac_rack = 1'b0;
    sample();
    check_output("idle_busy", bus.o_busy, 0);

    // Reset in the middle of a ch2 read.
    next_cycle();
    bus.i_ch_rd_req[2] = 1'b1;
    bus.i_ch_addr[2]   = 7'h33;
    next_cycle();
    sample();
    check_output("mid_busy", bus.o_busy, 1);
    check_output("mid_gnt",  bus.o_gnt_id, 2);
    #2;
    rst_n = 1'b0;
    bus.i_rac_rack = 1'b1;
    #1;
    check_output("arst_busy",   bus.o_busy, 0);
    check_output("arst_rd_req", bus.o_rac_rd_req, 0);
    check_output("arst_gnt",    bus.o_gnt_id, 0);
    check_output("arst_addr",   bus.o_rac_addr, 0);
    check_output("arst_rack",   bus.o_ch_rack, 0);
    bus.i_rac_rack     = 1'b0;
    bus.i_ch_rd_req[2] = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Fairness: all channels write continuously, order restarts at ch0.
    bus.i_ch_addr[0] = 7'h10;
    bus.i_ch_addr[1] = 7'h11;
    bus.i_ch_addr[2] = 7'h12;
    bus.i_ch_wr_req  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ch = k % 3;
      next_cycle();
      if (k > 0) bus.i_ch_wr_req[(k - 1) % 3] = 1'b1;
      sample();
      check_output($sformatf("fair_gnt_%0d", k), bus.o_gnt_id, exp_ch);
      check_output($sformatf("fair_addr_%0d", k), bus.o_rac_addr, 32'h10 + exp_ch);
      next_cycle();
      bus.i_rac_wack = 1'b1;
      sample();
      check_output($sformatf("fair_wack_%0d", k), bus.o_ch_wack, 32'd1 << exp_ch);
      next_cycle();
      bus.i_rac_wack = 1'b0;
      if (k == 5) bus.i_ch_wr_req = '0;
      else bus.i_ch_wr_req[exp_ch] = 1'b0;
      sample();
      check_output($sformatf("fair_idle_%0d", k), bus.o_busy, 0);
    end

`ifdef HV_ACC_ARB_TOUT_EN
    // Watchdog fires on the 4th BUSY cycle with no ack.
    next_cycle();
    bus.i_ch_wr_req[1] = 1'b1;
    bus.i_ch_addr[1]   = 7'h44;
    for (int c = 1; c <= TOUT; c++) begin
      next_cycle();
      sample();
      check_output($sformatf("tout_c%0d", c), bus.o_ch_tout, (c == TOUT) ? 3'b010 : 3'b000);
    end
    next_cycle();
    bus.i_ch_wr_req[1] = 1'b0;
    sample();
    check_output("tout_after_busy", bus.o_busy, 0);
    check_output("tout_after_req",  bus.o_rac_wr_req, 0);
    check_output("tout_after_tout", bus.o_ch_tout, 0);

    // An ack on the limit cycle wins over the watchdog.
    bus.i_ch_wr_req[1] = 1'b1;
    for (int c = 1; c <= TOUT; c++) begin
      next_cycle();
      if (c == TOUT) bus.i_rac_wack = 1'b1;
    end
    sample();
    check_output("tout_race_wack", bus.o_ch_wack, 3'b010);
    check_output("tout_race_tout", bus.o_ch_tout, 0);
    next_cycle();
    bus.i_rac_wack     = 1'b0;
    bus.i_ch_wr_req[1] = 1'b0;
    sample();
    check_output("tout_race_busy", bus.o_busy, 0);
`else
    // Without the watchdog BUSY waits indefinitely and o_ch_tout stays 0.
    next_cycle();
    bus.i_ch_wr_req[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      sample();
      check_output($sformatf("notout_tout_c%0d", c), bus.o_ch_tout, 0);
    end
    check_output("notout_busy", bus.o_busy, 1);
    next_cycle();
    bus.i_rac_wack = 1'b1;
    sample();
    check_output("notout_wack", bus.o_ch_wack, 3'b010);
    next_cycle();
    bus.i_rac_wack     = 1'b0;
    bus.i_ch_wr_req[1] = 1'b0;
    sample();
    check_output("notout_idle", bus.o_busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
